zaq_host_initiator: RTL and testbench

Host-side bus initiator that drives the zaq register block's strobe interface (write/read strobes, 5-bit address, 64-bit din, pair-write flag, 32-bit dout). It accepts single commands on a valid/ready port and sequences setup/strobe/hold phases on the register bus. It returns read data, or a write acknowledge, on a valid/ready response port. It also supports a hardware poll loop that re-reads a register until masked bits set or a timeout expires.

---
 rtl/zaq_bus_pkg.sv | 15 +
 rtl/zaq_phase_cnt.sv | 18 +
 rtl/zaq_host_initiator.sv | 146 ++++++++++++++
 tb/tb_zaq_host_initiator.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/zaq_bus_pkg.sv
// zaq_bus_pkg: op encodings, initiator states and register map shared with the zaq register block
package zaq_bus_pkg;
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_PAIR  = 2'b10;
    localparam logic [1:0] OP_POLL  = 2'b11;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, POLL_CHK, RESP} state_t;

    localparam logic [4:0] REG_CTRL = 5'h00;
    localparam logic [4:0] REG_PAIR = 5'h02;
    localparam logic [4:0] REG_DATA = 5'h0A;
    localparam logic [4:0] REG_STAT = 5'h0E;
    localparam logic [4:0] REG_LAST = 5'h0F;
endpackage

// File: rtl/zaq_phase_cnt.sv
// zaq_phase_cnt: 4-bit loadable down-counter; done while the count sits at zero
module zaq_phase_cnt (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] value,
    output logic       done
);
    logic [3:0] cnt;

    // load takes priority; otherwise count down and park at zero
    always_ff @(posedge sysclk or posedge reset)
        if (reset) cnt <= 4'd0;
        else if (load) cnt <= value;
        else if (cnt != 4'd0) cnt <= cnt - 4'd1;

    assign done = cnt == 4'd0;
endmodule

// File: rtl/zaq_host_initiator.sv
// zaq_host_initiator: sequences setup/strobe/hold cycles on the zaq register strobe bus, with a hardware poll loop
module zaq_host_initiator
    import zaq_bus_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int POLL_MAX   = 255
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_addr,
    input  logic [63:0] cmd_wdata,
    input  logic [31:0] cmd_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        bus_wrb,
    output logic        bus_rdb,
    output logic [4:0]  bus_addr,
    output logic [63:0] bus_din,
    output logic        bus_pair,
    input  logic [31:0] bus_dout,
    output logic        busy
);
    if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
        $error("SETUP_CYC must be 1..15");
    end
    if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe
        $error("STROBE_CYC must be 1..15");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
        $error("HOLD_CYC must be 1..15");
    end
    if (POLL_MAX < 1 || POLL_MAX > 255) begin : g_bad_poll
        $error("POLL_MAX must be 1..255");
    end

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
    localparam logic [7:0] POLL_LIM  = 8'(POLL_MAX);

    state_t      state, state_d;
    logic [1:0]  op;
    logic [4:0]  addr;
    logic [63:0] din;
    logic [31:0] mask, data;
    logic [7:0]  poll_cnt, cnt_p1;
    logic        err, alive, hit, give_up, is_wr, accept;
    logic        ph_load, ph_done;
    logic [3:0]  ph_val;

    zaq_phase_cnt u_phase (
        .sysclk (sysclk),
        .reset  (reset),
        .load   (ph_load),
        .value  (ph_val),
        .done   (ph_done)
    );

    assign is_wr   = op == OP_WRITE || op == OP_PAIR;
    assign accept  = cmd_valid && cmd_ready;
    assign cnt_p1  = poll_cnt + 8'd1;
    assign hit     = (data & mask) != 32'd0 || mask == 32'd0;
    assign give_up = !hit && cnt_p1 == POLL_LIM;

    // state register; reset drops straight back to IDLE so strobes release at once
    always_ff @(posedge sysclk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_d;

    // next state and phase-counter loads
    always_comb begin
        state_d = state;
        ph_load = 1'b0;
        ph_val  = SETUP_LD;
        case (state)
            IDLE: begin
                state_d = accept ? SETUP : IDLE;
                ph_load = accept;
            end
            SETUP: begin
                state_d = ph_done ? STROBE : SETUP;
                ph_load = ph_done;
                ph_val  = STROBE_LD;
            end
            STROBE: begin
                state_d = ph_done ? HOLD : STROBE;
                ph_load = ph_done;
                ph_val  = HOLD_LD;
            end
            HOLD:     state_d = !ph_done ? HOLD : op == OP_POLL ? POLL_CHK : RESP;
            POLL_CHK: begin
                state_d = (hit || give_up) ? RESP : SETUP;
                ph_load = !(hit || give_up);
            end
            RESP:     state_d = rsp_ready ? IDLE : RESP;
            default:  state_d = IDLE;
        endcase
    end

    // command latch, read capture at the last strobe edge, and poll bookkeeping
    always_ff @(posedge sysclk or posedge reset)
        if (reset) begin
            alive    <= 1'b0;
            op       <= OP_READ;
            addr     <= 5'd0;
            din      <= 64'd0;
            mask     <= 32'd0;
            data     <= 32'd0;
            err      <= 1'b0;
            poll_cnt <= 8'd0;
        end else begin
            alive <= 1'b1;
            if (state == IDLE && accept) begin
                op       <= cmd_op;
                addr     <= cmd_addr;
                din      <= cmd_op == OP_PAIR ? cmd_wdata : {32'd0, cmd_wdata[31:0]};
                mask     <= cmd_mask;
                data     <= 32'd0;
                err      <= 1'b0;
                poll_cnt <= 8'd0;
            end
            if (state == STROBE && ph_done && !is_wr) data <= bus_dout;
            if (state == POLL_CHK) begin
                err      <= give_up;
                poll_cnt <= cnt_p1;
            end
        end

    assign cmd_ready = alive && state == IDLE;
    assign busy      = state != IDLE;
    assign rsp_valid = state == RESP;
    assign rsp_data  = data;
    assign rsp_err   = err;
    assign bus_wrb   = !(state == STROBE && is_wr);
    assign bus_rdb   = !(state == STROBE && !is_wr);
    assign bus_addr  = addr;
    assign bus_din   = din;
    assign bus_pair  = op == OP_PAIR && (state == SETUP || state == STROBE || state == HOLD);
endmodule

// File: tb/tb_zaq_host_initiator.sv
// tb_zaq_host_initiator: directed checks of bus timing, responses, polling and mid-operation reset
module tb_zaq_host_initiator;
    import zaq_bus_pkg::*;

    logic        sysclk = 1'b0, reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [4:0]  cmd_addr = 5'd0;
    logic [63:0] cmd_wdata = 64'd0;
    logic [31:0] cmd_mask = 32'd0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_data;
    logic        bus_wrb, bus_rdb, bus_pair, busy;
    logic [4:0]  bus_addr;
    logic [63:0] bus_din;
    logic [31:0] bus_dout = 32'd0;

    int n_chk = 0, n_pass = 0, both_low = 0;

    zaq_host_initiator #(.POLL_MAX(4)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_mask  (cmd_mask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .bus_wrb   (bus_wrb),
        .bus_rdb   (bus_rdb),
        .bus_addr  (bus_addr),
        .bus_din   (bus_din),
        .bus_pair  (bus_pair),
        .bus_dout  (bus_dout),
        .busy      (busy)
    );

    always #5 sysclk = ~sysclk;

    // watch for both strobes low at the same time
    always @(negedge sysclk)
        if (!bus_wrb && !bus_rdb) both_low <= both_low + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(negedge sysclk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [4:0] a, input logic [63:0] w, input logic [31:0] m);
        cmd_valid = 1'b1;
        cmd_op    = o;
        cmd_addr  = a;
        cmd_wdata = w;
        cmd_mask  = m;
        @(posedge sysclk);
        #1;
        cmd_valid = 1'b0;
        step();
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 300) begin
            step();
            n++;
        end
        check(tag, rsp_valid, 1'b1);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic poll_run(input string tag, input logic set_hit, input int exp_pulses,
                            input logic [31:0] exp_data, input logic exp_err);
        int pulses = 0, n = 0;
        logic prev = 1'b1;
        bus_dout = set_hit ? 32'd0 : 32'h3;
        issue(OP_POLL, REG_STAT, 64'd0, 32'h4);
        while (!rsp_valid && n < 300) begin
            if (!bus_rdb && prev) begin
                pulses++;
                if (set_hit && pulses == 3) bus_dout = 32'h4;
            end
            prev = bus_rdb;
            step();
            n++;
        end
        check({tag, "_rsp"}, rsp_valid, 1'b1);
        check({tag, "_pulses"}, pulses, exp_pulses);
        check({tag, "_data"}, rsp_data, exp_data);
        check({tag, "_err"}, rsp_err, exp_err);
        consume();
    endtask

    initial begin
        step();
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_wrb", bus_wrb, 1'b1);
        check("rst_rdb", bus_rdb, 1'b1);
        check("rst_addr", bus_addr, 5'd0);
        check("rst_din", bus_din, 64'd0);
        check("rst_pair", bus_pair, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 34'd0);
        reset = 1'b0;
        step();
        check("rel_cmd_ready", cmd_ready, 1'b1);

        // single write: T+1 setup, T+2..T+3 strobe, T+4 hold, T+5 response
        issue(OP_WRITE, REG_CTRL, 64'hCAFEF00D_DEADBEEF, 32'd0);
        check("wr_t1_wrb", bus_wrb, 1'b1);
        check("wr_t1_busy", busy, 1'b1);
        step();
        check("wr_t2_wrb", bus_wrb, 1'b0);
        check("wr_t2_addr", bus_addr, REG_CTRL);
        check("wr_t2_din", bus_din, 64'h00000000_DEADBEEF);
        step();
        check("wr_t3_wrb", bus_wrb, 1'b0);
        step();
        check("wr_t4_wrb", bus_wrb, 1'b1);
        check("wr_t4_rsp", rsp_valid, 1'b0);
        step();
        check("wr_t5_rsp", rsp_valid, 1'b1);
        check("wr_t5_data", rsp_data, 32'd0);
        check("wr_t5_err", rsp_err, 1'b0);
        consume();
        check("wr_done_rsp", rsp_valid, 1'b0);
        check("wr_done_ready", cmd_ready, 1'b1);

        // pair write: flag, address and data stable from setup to hold
        issue(OP_PAIR, REG_PAIR, 64'h11111111_22222222, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pair_c%0d_flag", i), bus_pair, 1'b1);
            check($sformatf("pair_c%0d_addr", i), bus_addr, REG_PAIR);
            check($sformatf("pair_c%0d_din", i), bus_din, 64'h11111111_22222222);
            check($sformatf("pair_c%0d_rdb", i), bus_rdb, 1'b1);
            step();
        end
        wait_rsp("pair_rsp");
        check("pair_resp_flag", bus_pair, 1'b0);
        consume();

        // read: only the value present on the last strobe cycle is captured
        issue(OP_READ, REG_DATA, 64'd0, 32'd0);
        step();
        bus_dout = 32'h12345678;
        check("rd_t2_rdb", bus_rdb, 1'b0);
        step();
        bus_dout = 32'hA5A5A5A5;
        step();
        bus_dout = 32'hFFFFFFFF;
        step();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rd_stall%0d_valid", i), rsp_valid, 1'b1);
            check($sformatf("rd_stall%0d_data", i), rsp_data, 32'hA5A5A5A5);
            check($sformatf("rd_stall%0d_ready", i), cmd_ready, 1'b0);
            step();
        end
        consume();
        check("rd_done_rsp", rsp_valid, 1'b0);
        check("rd_done_ready", cmd_ready, 1'b1);

        // polls with POLL_MAX=4
        poll_run("poll_hit", 1'b1, 3, 32'h4, 1'b0);
        poll_run("poll_timeout", 1'b0, 4, 32'h3, 1'b1);

        // reset in the middle of a write strobe
        issue(OP_WRITE, REG_CTRL, 64'h0000_0000_0BADBEEF, 32'd0);
        step();
        check("rst_mid_wrb_low", bus_wrb, 1'b0);
        reset = 1'b1;
        #1;
        check("rst_mid_wrb", bus_wrb, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ready", cmd_ready, 1'b0);
        step();
        check("rst_mid_rsp", rsp_valid, 1'b0);
        reset = 1'b0;
        step();
        check("rst_mid_rsp_after", rsp_valid, 1'b0);
        check("rst_mid_ready_after", cmd_ready, 1'b1);
        bus_dout = 32'h0BADF00D;
        issue(OP_READ, REG_LAST, 64'd0, 32'd0);
        wait_rsp("post_rst_rsp");
        check("post_rst_data", rsp_data, 32'h0BADF00D);
        check("post_rst_err", rsp_err, 1'b0);
        consume();

        check("never_both_low", both_low, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
